// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and LSU writeback requests in, register-file write port out.
// Latency: n/a (signal bundle only).
// Backpressure: alu_ready / lsu_ready returned to the requesters; the register-file port has none.
// Ports (master = requesters + register file side, slave = arbiter):
//   alu_valid/alu_addr/alu_data/alu_ready  ALU writeback request and its accept
//   lsu_valid/lsu_addr/lsu_data/lsu_ready  LSU writeback request and its accept
//   regWriteAddr/dataToWrite/toWrite       registered register-file write port
//   fifo_count                             LSU buffer occupancy, 0..2
interface wb_arbiter_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  alu_valid;
  logic [4:0]            alu_addr;
  logic [WORD_WIDTH-1:0] alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [4:0]            lsu_addr;
  logic [WORD_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic [4:0]            regWriteAddr;
  logic [WORD_WIDTH-1:0] dataToWrite;
  logic                  toWrite;
  logic [1:0]            fifo_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready,
    input  regWriteAddr, dataToWrite, toWrite, fifo_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready,
    output regWriteAddr, dataToWrite, toWrite, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto one register-file write port, ALU first.
// Latency: ALU request -> toWrite 1 edge; LSU request -> toWrite 2 edges minimum (buffered).
// Backpressure: lsu_ready drops while the 2-entry LSU buffer is full; alu_ready is always 1
//   unless WB_STARVE_GUARD_EN is defined, in which case it drops for one cycle after the
//   LSU head has been passed over on three consecutive edges.
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   bus        wb_arbiter_if.slave (ALU/LSU requests in, register-file write port out)
// Optional feature macro: WB_STARVE_GUARD_EN (LSU starvation guard).

// Small generic synchronous FIFO with occupancy output. Reads are from the registered
// head entry (no fall-through from the push side), so a pushed entry is visible at the
// head only after the push edge.
module wb_arbiter_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             push_rdy_o,
  input  logic             pop_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_do;
  logic             pop_do;

  // Readiness depends on stored occupancy only, never on the pop request.
  assign push_rdy_o = (count_q != CNT_W'(DEPTH));
  assign pop_vld_o  = (count_q != '0);
  assign pop_dat_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  assign push_do = push_vld_i && push_rdy_o;
  assign pop_do  = pop_i && pop_vld_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_do) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_do) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push_do, pop_do})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_do) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

module wb_arbiter #(
  parameter int WORD_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  typedef struct packed {
    logic [4:0]            addr;
    logic [WORD_WIDTH-1:0] data;
  } wb_req_t;

  localparam int REQ_W = $bits(wb_req_t);

  wb_req_t               lsu_req;
  wb_req_t               head_req;
  wb_req_t               sel_req;
  logic                  head_vld;
  logic                  lsu_ready;
  logic                  alu_ready;
  logic                  alu_sel;
  logic                  fifo_sel;
  logic                  sel_vld;
  logic                  wr_en;
  logic [1:0]            fifo_count;

  logic [4:0]            regWriteAddr_q, regWriteAddr_d;
  logic [WORD_WIDTH-1:0] dataToWrite_q, dataToWrite_d;
  logic                  toWrite_q, toWrite_d;

  assign lsu_req = '{addr: bus.lsu_addr, data: bus.lsu_data};

  // Every LSU result goes through the buffer, even when it is empty, so LSU
  // writes always take at least a push edge and a pop edge.
  wb_arbiter_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (2)
  ) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (bus.lsu_valid),
    .push_dat_i (lsu_req),
    .push_rdy_o (lsu_ready),
    .pop_i      (fifo_sel),
    .pop_vld_o  (head_vld),
    .pop_dat_o  (head_req),
    .count_o    (fifo_count)
  );

`ifdef WB_STARVE_GUARD_EN
  // Counts edges on which a buffered LSU entry was passed over. At 3 the ALU is
  // held off for one cycle so the head drains; any pop clears the count. The
  // count can only reach 3 while the buffer is non-empty, because the buffer
  // empties only through a pop.
  logic [1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (fifo_sel) begin
      starve_d = 2'd0;
    end else if (head_vld && (starve_q != 2'd3)) begin
      starve_d = starve_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign alu_ready = (starve_q != 2'd3);
`else
  // ALU has strict priority; the LSU buffer may wait indefinitely.
  assign alu_ready = 1'b1;
`endif

  // At most one source per edge: accepted ALU request first, else buffer head.
  assign alu_sel  = bus.alu_valid && alu_ready;
  assign fifo_sel = !alu_sel && head_vld;

  always_comb begin
    sel_req = '0;
    sel_vld = 1'b0;
    if (alu_sel) begin
      sel_req = '{addr: bus.alu_addr, data: bus.alu_data};
      sel_vld = 1'b1;
    end else if (fifo_sel) begin
      sel_req = head_req;
      sel_vld = 1'b1;
    end
  end

  // Register 0 is hard-wired: the request is consumed but nothing is written
  // and the write port keeps its previous address/data.
  assign wr_en = sel_vld && (sel_req.addr != 5'd0);

  always_comb begin
    regWriteAddr_d = regWriteAddr_q;
    dataToWrite_d  = dataToWrite_q;
    toWrite_d      = wr_en;
    if (wr_en) begin
      regWriteAddr_d = sel_req.addr;
      dataToWrite_d  = sel_req.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteAddr_q <= 5'd0;
      dataToWrite_q  <= '0;
      toWrite_q      <= 1'b0;
    end else begin
      regWriteAddr_q <= regWriteAddr_d;
      dataToWrite_q  <= dataToWrite_d;
      toWrite_q      <= toWrite_d;
    end
  end

  assign bus.alu_ready    = alu_ready;
  assign bus.lsu_ready    = lsu_ready;
  assign bus.regWriteAddr = regWriteAddr_q;
  assign bus.dataToWrite  = dataToWrite_q;
  assign bus.toWrite      = toWrite_q;
  assign bus.fifo_count   = fifo_count;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: WORD_WIDTH, default 32 (`WORD_WIDTH), register data width.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU writeback request present.
REQ-005 alu_addr  input  5  ALU destination register.
REQ-006 alu_data  input  WORD_WIDTH  ALU result.
REQ-007 alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-008 lsu_valid  input  1  load/long-latency unit writeback request present.
REQ-009 lsu_addr  input  5  LSU destination register.
REQ-010 lsu_data  input  WORD_WIDTH  LSU result.
REQ-011 lsu_ready  output  1  LSU request accepted this cycle when high with lsu_valid.
REQ-012 regWriteAddr  output  5  register-file write address, registered.
REQ-013 dataToWrite  output  WORD_WIDTH  register-file write data, registered.
REQ-014 toWrite  output  1  register-file write enable, registered, one-cycle pulse per write.
REQ-015 fifo_count  output  2  LSU buffer occupancy, 0..2.

Function
REQ-016 LSU requests SHALL enter a 2-entry in-order FIFO; lsu_ready = (fifo_count < 2), combinational from state only.
REQ-017 LSU push SHALL occur on an edge where lsu_valid && lsu_ready; no bypass around the FIFO, even when empty.
REQ-018 Each edge SHALL select at most one source: ALU if alu_valid && alu_ready, else FIFO head if fifo_count > 0, else none.
REQ-019 Selected source SHALL load regWriteAddr/dataToWrite on that edge; toWrite = 1 for the following cycle only.
REQ-020 Latency: ALU request to toWrite = 1 edge; LSU request to toWrite = 2 edges minimum (push edge, then pop edge).
REQ-021 Selection with address 0 SHALL consume the request (FIFO pops, ALU is accepted) but leave toWrite = 0; regWriteAddr/dataToWrite unchanged.
REQ-022 No selection: toWrite = 0; regWriteAddr/dataToWrite hold their previous values.
REQ-023 Same-edge push and pop SHALL leave fifo_count unchanged and preserve order; push while fifo_count = 2 is impossible (lsu_ready = 0).
REQ-024 ALU and FIFO head targeting the same register: ALU written first, FIFO entry written on a later cycle (last write wins); no merging.
REQ-025 Without the guard (REQ-029), alu_ready SHALL be constant 1.

Reset
REQ-026 rst high SHALL immediately force: toWrite = 0, regWriteAddr = 0, dataToWrite = 0, fifo_count = 0, starvation counter = 0.
REQ-027 During and after reset, lsu_ready = 1 and alu_ready = 1; FIFO contents are discarded when reset asserts mid-operation; a write pulse in flight is dropped.
REQ-028 First selection after reset deassertion SHALL be sampled on the first posedge with rst low.

Configuration
REQ-029 Macro WB_STARVE_GUARD_EN: when defined, a 2-bit counter SHALL increment (saturating at 3) on each edge where fifo_count > 0 and no pop occurs, and clear on any pop or reset.
REQ-030 With WB_STARVE_GUARD_EN defined and counter = 3: alu_ready = 0 that cycle and the FIFO head SHALL be selected.
REQ-031 Without WB_STARVE_GUARD_EN: no counter; ALU strictly wins and the FIFO may wait indefinitely.

Verification
REQ-032 ALU only: alu_valid=1, addr=8, data=0x1234 at edge 1 -> toWrite=1, regWriteAddr=8, dataToWrite=0x1234 in the cycle after edge 1, then toWrite=0.
REQ-033 LSU only: lsu addr=9, data=0xDEAD pushed at edge 1 -> fifo_count=1 after edge 1; toWrite with addr 9 after edge 2; fifo_count=0.
REQ-034 Contention: ALU valid continuously (addr 10), LSU pushes 3 entries -> lsu_ready=0 after two pushes; without the macro, no LSU write while ALU is valid; LSU entries are written in order after the ALU drops.
REQ-035 Address 0: ALU write to addr 0 with data 0xFFFF -> alu_ready=1, toWrite stays 0, and the outputs hold their prior values.
REQ-036 Guard (macro defined): FIFO nonempty, ALU valid every cycle -> after 3 starved edges, alu_ready=0 for one cycle and the LSU entry is written; the counter returns to 0.
REQ-037 Reset mid-operation: fifo_count=2 and toWrite=1, then assert rst asynchronously -> toWrite=0, fifo_count=0, and lsu_ready=1 without waiting for a clock edge.
